tcu_noc_mc_fifo: RTL

Multi-channel NoC flit buffer for the TCU NoC ports. It has NUM_CH independent input channels, each with its own FIFO, and one shared output port. A round-robin arbiter that is aware of bursts merges the channels onto the output. A burst is never interleaved with flits from another channel. Optionally, a burst is released only after its last flit has been stored. The block sits between the TCU controller and the NoC router, replacing per-port single-channel buffering where several traffic classes share one link.

---
 rtl/tcu_noc_mc_fifo_pkg.sv | 23 ++
 rtl/tcu_noc_mc_fifo_rr_arbiter.sv | 122 ++++++++++++
 rtl/tcu_noc_mc_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tcu_noc_mc_fifo_pkg.sv
// Shared constants and types for the multi-channel NoC flit buffer.
// Flit geometry comes from the NoC field sizes; the burst flag is the
// MSB of a packed flit. The arbiter lock state is an enum.
package tcu_noc_mc_fifo_pkg;

    localparam int NOC_HEADER_SIZE      = 38;
    localparam int NOC_PAYLOAD_SIZE     = 64;
    localparam int NOC_ARQ_SIZE         = 6;
    localparam int NOC_FLIT_WIDTH       = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE - NOC_ARQ_SIZE;
    localparam int FLIT_BURST_BIT       = NOC_FLIT_WIDTH - 1;
    localparam int MAX_BURST_LENGTH_MSG = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcu_noc_mc_fifo_rr_arbiter.sv
// Burst-aware round-robin arbiter for tcu_noc_mc_fifo.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   empty, full      : per-channel FIFO status
//   head_burst       : burst bit of each channel's head flit
//   done_nz          : channel holds at least one fully stored burst
//   pop              : the flit on the output is consumed this cycle
//   valid            : a flit is offered on the output
//   grant            : channel whose head flit is offered
//   locked           : a burst is in progress on channel 'grant'
module tcu_noc_mc_fifo_rr_arbiter
    import tcu_noc_mc_fifo_pkg::*;
#(
    parameter int NUM_CH              = 2,
    parameter int POP_FULL_BURST_ONLY = 1,
    parameter int CH_W                = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] head_burst,
    input  logic [NUM_CH-1:0] done_nz,
    input  logic              pop,
    output logic              valid,
    output logic [CH_W-1:0]   grant,
    output logic              locked
);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] elig;
    logic              rr_found;
    logic [CH_W-1:0]   rr_pick;
    logic [CH_W:0]     idx;
    logic [CH_W-1:0]   grant_inc;

    // A burst header may leave only once the whole burst is stored, unless
    // the FIFO is full: a burst longer than the FIFO must stream through.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = !empty[c] && (!head_burst[c] || (POP_FULL_BURST_ONLY == 0) ||
                                     done_nz[c] || full[c]);
        end
    end

    // First eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (!rr_found && elig[idx[CH_W-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = idx[CH_W-1:0];
            end
        end
    end

    assign grant_inc = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ARB_IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Lock and pointer move only on a pop, so a stalled grant stays put.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (pop) begin
            case (state_q)
                ARB_IDLE: begin
                    if (head_burst[grant]) begin
                        state_d   = ARB_LOCKED;
                        lock_ch_d = grant;
                    end else begin
                        rr_ptr_d  = grant_inc;
                    end
                end
                ARB_LOCKED: begin
                    if (!head_burst[lock_ch_q]) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = grant_inc;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        valid  = 1'b0;
        grant  = '0;
        locked = 1'b0;
        case (state_q)
            ARB_LOCKED: begin
                valid  = !empty[lock_ch_q];
                grant  = lock_ch_q;
                locked = 1'b1;
            end
            default: begin
                valid = rr_found;
                grant = rr_pick;
            end
        endcase
    end

endmodule

// File: rtl/tcu_noc_mc_fifo.sv
// Multi-channel NoC flit buffer: one first-word-fall-through FIFO per input
// channel, merged onto a single output by a burst-aware round-robin arbiter.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   noc_wrreq_i      : per-channel write request
//   noc_flit_i       : channel c at [c*FLIT_WIDTH +: FLIT_WIDTH], MSB = burst
//   noc_stall_o      : per-channel back-pressure
//   noc_wrreq_o      : output flit valid
//   noc_flit_o       : output flit, zero while noc_wrreq_o=0
//   noc_ch_o         : source channel of noc_flit_o
//   noc_stall_i      : downstream back-pressure
//   level_o          : per-channel fill level, DEPTH_LOG2+1 bits each
module tcu_noc_mc_fifo
    import tcu_noc_mc_fifo_pkg::*;
#(
    parameter int NUM_CH              = 2,
    parameter int FLIT_WIDTH          = FLIT_BURST_BIT + 1,
    parameter int DEPTH_LOG2          = $clog2(MAX_BURST_LENGTH_MSG),
    parameter int NOC_MASTER          = 0,
    parameter int POP_FULL_BURST_ONLY = 1,
    localparam int CH_W               = ch_width(NUM_CH),
    localparam int LVL_W              = DEPTH_LOG2 + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [NUM_CH-1:0]            noc_wrreq_i,
    input  logic [NUM_CH*FLIT_WIDTH-1:0] noc_flit_i,
    output logic [NUM_CH-1:0]            noc_stall_o,
    output logic                         noc_wrreq_o,
    output logic [FLIT_WIDTH-1:0]        noc_flit_o,
    output logic [CH_W-1:0]              noc_ch_o,
    input  logic                         noc_stall_i,
    output logic [NUM_CH*LVL_W-1:0]      level_o
);

    localparam int DEPTH     = 2 ** DEPTH_LOG2;
    localparam int BURST_BIT = FLIT_WIDTH - 1;

    logic [NUM_CH-1:0]     full, empty, push, head_burst, done_nz;
    logic [LVL_W-1:0]      level [NUM_CH];
    logic [FLIT_WIDTH-1:0] head_flit [NUM_CH];
    logic                  arb_valid, arb_locked, pop;
    logic [CH_W-1:0]       grant;

    assign pop = arb_valid && !noc_stall_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [FLIT_WIDTH-1:0] mem [DEPTH];
        logic [LVL_W-1:0]      wr_ptr, rd_ptr, done_cnt;
        logic                  in_burst_in;
        logic [FLIT_WIDTH-1:0] flit_in;
        logic                  pop_ch, last_in, last_out;

        assign flit_in       = noc_flit_i[c*FLIT_WIDTH +: FLIT_WIDTH];
        assign level[c]      = wr_ptr - rd_ptr;
        assign full[c]       = (level[c] == LVL_W'(DEPTH));
        assign empty[c]      = (level[c] == '0);
        assign push[c]       = noc_wrreq_i[c] && !full[c];
        assign head_flit[c]  = mem[rd_ptr[DEPTH_LOG2-1:0]];
        assign head_burst[c] = head_flit[c][BURST_BIT];
        assign done_nz[c]    = (done_cnt != '0);
        assign pop_ch        = pop && (grant == CH_W'(c));

        // done_cnt counts bursts whose closing flit is stored; the closing
        // flit is a burst=0 flit following burst=1 flits on this channel.
        assign last_in  = push[c] && !flit_in[BURST_BIT] && in_burst_in;
        assign last_out = pop_ch && arb_locked && !head_burst[c];

        // Stall uses the registered full flag even when a pop frees a slot.
        assign noc_stall_o[c] = full[c] || ((NOC_MASTER != 0) && !noc_wrreq_i[c]);
        assign level_o[c*LVL_W +: LVL_W] = level[c];

        always_ff @(posedge clk_i) begin
            if (push[c]) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= flit_in;
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                done_cnt    <= '0;
                in_burst_in <= 1'b0;
            end else begin
                if (push[c]) begin
                    wr_ptr      <= wr_ptr + 1'b1;
                    in_burst_in <= flit_in[BURST_BIT];
                end
                if (pop_ch) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({last_in, last_out})
                    2'b10:   done_cnt <= done_cnt + 1'b1;
                    2'b01:   done_cnt <= done_cnt - 1'b1;
                    default: done_cnt <= done_cnt;
                endcase
            end
        end
    end

    tcu_noc_mc_fifo_rr_arbiter #(
        .NUM_CH              (NUM_CH),
        .POP_FULL_BURST_ONLY (POP_FULL_BURST_ONLY),
        .CH_W                (CH_W)
    ) u_arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .empty      (empty),
        .full       (full),
        .head_burst (head_burst),
        .done_nz    (done_nz),
        .pop        (pop),
        .valid      (arb_valid),
        .grant      (grant),
        .locked     (arb_locked)
    );

    assign noc_wrreq_o = arb_valid;
    assign noc_ch_o    = grant;
    assign noc_flit_o  = arb_valid ? head_flit[grant] : '0;

endmodule
